// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and helpers for the binary-to-BCD conversion arbiter.
//   state_t        : controller states (IDLE, SHIFT, DONE)
//   BIN_W_DEF      : default binary operand width
//   BCD_DIGITS_DEF : default number of BCD result digits
//   bcd_add3       : double-dabble digit adjust (add 3 when the digit is >= 5)
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BIN_W_DEF      = 24;
  localparam int BCD_DIGITS_DEF = 8;

  // A digit of 5..9 becomes 8..12, so the following left shift carries
  // correctly into the next decimal digit.
  function automatic logic [3:0] bcd_add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// bcd_dabble_seq: sequential double-dabble engine, one operand bit per clock.
//   clk, rst  : clock and synchronous active-high reset (control only)
//   start     : load bin, clear the accumulator and begin converting
//   bin       : unsigned binary operand, sampled when start is high
//   last      : high during the final shift cycle of a conversion
//   bcd_next  : accumulator value after the current shift; on the last
//               cycle this is the finished packed BCD result
module bcd_dabble_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W      = BIN_W_DEF,
  parameter int BCD_DIGITS = BCD_DIGITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    last,
  output logic [4*BCD_DIGITS-1:0] bcd_next
);

  localparam int ACC_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  logic              active;
  logic [BIN_W-1:0]  shreg;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  adj;
  logic [CNT_W-1:0]  cnt;

  assign last = active && (cnt == '0);

  // Adjust every digit, then shift left taking the operand MSB as new bit 0.
  always_comb begin
    adj = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      adj[4*i +: 4] = bcd_add3(acc[4*i +: 4]);
    end
    bcd_next = {adj[ACC_W-2:0], shreg[BIN_W-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
    end else if (last) begin
      active <= 1'b0;
    end
  end

  // Datapath registers are only meaningful while active, so they carry no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      shreg <= bin;
      acc   <= '0;
      cnt   <= CNT_W'(BIN_W - 1);
    end else if (active) begin
      shreg <= {shreg[BIN_W-2:0], 1'b0};
      acc   <= bcd_next;
      cnt   <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: round-robin time-sharing of one double-dabble engine.
//   clk, rst   : clock and synchronous active-high reset
//   req_valid  : per-requester level request strobes
//   req_bin    : packed operands, requester i at [i*BIN_W +: BIN_W]
//   req_ready  : one-hot grant, only ever high in IDLE
//   rsp_valid  : result available (held until rsp_ready)
//   rsp_id     : requester index the result belongs to
//   rsp_bcd    : packed BCD result, digit 0 in bits [3:0]
//   rsp_ready  : consumer accepts the result
//   busy       : a conversion is in flight or awaiting acceptance
module bcd_convert_arbiter
  import bcd_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int BIN_W      = BIN_W_DEF,
  parameter int BCD_DIGITS = BCD_DIGITS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*BIN_W-1:0]   req_bin,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [4*BCD_DIGITS-1:0]    rsp_bcd,
  input  logic                       rsp_ready,
  output logic                       busy
);

  localparam int              ID_W    = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t                  state, state_n;
  logic [ID_W-1:0]         rr_ptr;
  logic                    gnt_any;
  logic [ID_W-1:0]         gnt_idx;
  logic [ID_W-1:0]         cand;
  int                      idx_sum;
  logic [BIN_W-1:0]        sel_bin;
  logic                    start;
  logic                    eng_last;
  logic [4*BCD_DIGITS-1:0] eng_bcd;

  // First requester at or above rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    idx_sum = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_sum = int'(rr_ptr) + k;
      if (idx_sum >= NUM_REQ) idx_sum = idx_sum - NUM_REQ;
      cand = ID_W'(idx_sum);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    sel_bin = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) sel_bin = req_bin[i*BIN_W +: BIN_W];
    end
  end

  always_comb begin
    state_n   = state;
    start     = 1'b0;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        if (gnt_any) begin
          req_ready[gnt_idx] = 1'b1;
          start              = 1'b1;
          state_n            = SHIFT;
        end
      end
      SHIFT:   if (eng_last) state_n = DONE;
      DONE:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Response register and round-robin pointer; reset also discards any
  // in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_bcd   <= '0;
    end else begin
      if (start) begin
        rsp_id <= gnt_idx;
        rr_ptr <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
      end
      if (state == SHIFT && eng_last) begin
        rsp_valid <= 1'b1;
        rsp_bcd   <= eng_bcd;
      end
      if (state == DONE && rsp_ready) rsp_valid <= 1'b0;
    end
  end

  bcd_dabble_seq #(
    .BIN_W      (BIN_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_engine (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (sel_bin),
    .last     (eng_last),
    .bcd_next (eng_bcd)
  );

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
module tb_bcd_convert_arbiter;

  localparam int N  = 4;
  localparam int BW = 24;
  localparam int BD = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*BW-1:0] req_bin;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [4*BD-1:0] rsp_bcd;
  logic            rsp_ready;
  logic            busy;

  bcd_convert_arbiter #(.NUM_REQ(N), .BIN_W(BW), .BCD_DIGITS(BD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_bin   (req_bin),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_bcd   (rsp_bcd),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Decimal digits by repeated division.
  function automatic logic [4*BD-1:0] to_bcd(input int unsigned v);
    logic [4*BD-1:0] r;
    r = '0;
    for (int i = 0; i < BD; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int unsigned get_bin(input int i);
    logic [BW-1:0] t;
    t = BW'(req_bin >> (i * BW));
    return 32'(t);
  endfunction

  // Behavioural model: idle / converting (countdown) / holding a result.
  int              m_phase = 0;
  int              m_left  = 0;
  int              m_ptr   = 0;
  int              m_id    = 0;
  int unsigned     m_opnd  = 0;
  logic [4*BD-1:0] m_bcd   = '0;
  bit              m_rv    = 1'b0;
  bit              m_init  = 1'b0;
  longint          cyc     = 0;

  int              gnt_q[$];
  longint          gnt_t[$];
  int              rid_q[$];
  logic [4*BD-1:0] rbcd_q[$];

  always @(negedge clk) begin
    int g;
    int idx;
    logic [N-1:0] exp_ready;
    cyc++;
    g = -1;
    if (m_phase == 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx[1:0]]) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g[1:0]] = 1'b1;

    if (m_init) begin
      chk("cyc_req_ready", 64'(req_ready), 64'(exp_ready));
      chk("cyc_rsp_valid", 64'(rsp_valid), 64'(m_rv));
      chk("cyc_busy",      64'(busy),      64'(m_phase != 0));
      chk("cyc_rsp_id",    64'(rsp_id),    64'(m_id));
      chk("cyc_rsp_bcd",   64'(rsp_bcd),   64'(m_bcd));
    end

    if ((req_ready & req_valid) != '0) begin
      for (int k = 0; k < N; k++) if (req_ready[k]) gnt_q.push_back(k);
      gnt_t.push_back(cyc);
    end
    if (rsp_valid && rsp_ready) begin
      rid_q.push_back(int'(rsp_id));
      rbcd_q.push_back(rsp_bcd);
    end

    if (rst) begin
      m_phase = 0; m_rv = 1'b0; m_id = 0; m_bcd = '0; m_ptr = 0; m_init = 1'b1;
    end else begin
      case (m_phase)
        0: if (g >= 0) begin
          m_id    = g;
          m_opnd  = get_bin(g);
          m_ptr   = (g + 1) % N;
          m_left  = BW;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2;
            m_rv    = 1'b1;
            m_bcd   = to_bcd(m_opnd);
          end
        end
        default: if (rsp_ready) begin
          m_phase = 0;
          m_rv    = 1'b0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string nm, input int limit);
    int n;
    n = 0;
    while (!rsp_valid && n < limit) begin tick(); n++; end
    chk(nm, 64'(rsp_valid), 64'd1);
  endtask

  task automatic wait_idle(input string nm, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin tick(); n++; end
    chk(nm, 64'(busy), 64'd0);
  endtask

  task automatic clear_logs();
    gnt_q.delete(); gnt_t.delete(); rid_q.delete(); rbcd_q.delete();
  endtask

  initial begin
    int lat;
    int n;
    int cnt1;
    rst = 1'b1; req_valid = '0; req_bin = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_busy",      64'(busy),      64'd0);
    chk("reset_rsp_bcd",   64'(rsp_bcd),   64'd0);
    chk("reset_rsp_id",    64'(rsp_id),    64'd0);

    // Requester 0 converts zero.
    rst = 1'b0;
    req_valid = 4'b0001;
    req_bin[0 +: BW] = 24'd0;
    #1 chk("s1_ready", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin tick(); lat++; end
    chk("s1_latency", 64'(lat), 64'd25);
    chk("s1_bcd", 64'(rsp_bcd), 64'd0);
    chk("s1_id",  64'(rsp_id),  64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("s1_released", 64'(rsp_valid), 64'd0);

    // Requester 2, maximum operand, result held with back-pressure.
    req_valid = 4'b0100;
    req_bin[2*BW +: BW] = 24'hFFFFFF;
    #1 chk("s2_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = 4'b0001;
    wait_rsp("s2_rsp_timeout", 40);
    for (int i = 0; i < 10; i++) begin
      chk("s2_hold_bcd",   64'(rsp_bcd),   64'h16777215);
      chk("s2_hold_id",    64'(rsp_id),    64'd2);
      chk("s2_hold_busy",  64'(busy),      64'd1);
      chk("s2_hold_ready", 64'(req_ready), 64'd0);
      chk("s2_hold_valid", 64'(rsp_valid), 64'd1);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    wait_idle("s2_idle_timeout", 40);

    // All four requesting continuously from rr_ptr=0.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    clear_logs();
    req_bin[0*BW +: BW] = 24'd1234;
    req_bin[1*BW +: BW] = 24'd99999;
    req_bin[2*BW +: BW] = 24'd5;
    req_bin[3*BW +: BW] = 24'd8388608;
    req_valid = 4'b1111;
    n = 0;
    while (rid_q.size() < 5 && n < 200) begin tick(); n++; end
    req_valid = '0;
    wait_idle("s3_idle_timeout", 60);
    chk("s3_rsp_count", 64'(rid_q.size() >= 5), 64'd1);
    if (rid_q.size() >= 5 && gnt_q.size() >= 5) begin
      chk("s3_gnt0", 64'(gnt_q[0]), 64'd0);
      chk("s3_gnt1", 64'(gnt_q[1]), 64'd1);
      chk("s3_gnt2", 64'(gnt_q[2]), 64'd2);
      chk("s3_gnt3", 64'(gnt_q[3]), 64'd3);
      chk("s3_gnt4", 64'(gnt_q[4]), 64'd0);
      chk("s3_bcd0", 64'(rbcd_q[0]), 64'h00001234);
      chk("s3_bcd1", 64'(rbcd_q[1]), 64'h00099999);
      chk("s3_bcd2", 64'(rbcd_q[2]), 64'h00000005);
      chk("s3_bcd3", 64'(rbcd_q[3]), 64'h08388608);
      chk("s3_id3",  64'(rid_q[3]),  64'd3);
    end

    // Single-requester sweep; operands change every cycle.
    clear_logs();
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    n = 0;
    while (rid_q.size() < 1000 && n < 30000) begin
      for (int i = 0; i < N; i++) req_bin[i*BW +: BW] = BW'($urandom);
      tick();
      n++;
    end
    req_valid = '0;
    wait_idle("s4_idle_timeout", 60);
    chk("s4_rsp_count", 64'(rid_q.size()), 64'd1000);
    cnt1 = 0;
    foreach (rid_q[i]) if (rid_q[i] == 1) cnt1++;
    chk("s4_all_id1", 64'(cnt1), 64'(rid_q.size()));
    for (int i = 1; i < gnt_t.size(); i++)
      chk("s4_spacing", 64'(gnt_t[i] - gnt_t[i-1]), 64'd26);

    // Random traffic with random back-pressure.
    for (int c = 0; c < 3000; c++) begin
      req_valid = N'($urandom);
      rsp_ready = 1'($urandom);
      for (int i = 0; i < N; i++) req_bin[i*BW +: BW] = BW'($urandom);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("rand_idle_timeout", 60);

    // Reset ten clocks into a conversion.
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("s5_busy",      64'(busy),      64'd0);
    chk("s5_ready",     64'(req_ready), 64'd0);
    req_valid = 4'b1000;
    #1 chk("s5_ready_3", 64'(req_ready), 64'b1000);
    req_valid = 4'b1001;
    #1 chk("s5_ready_0_first", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("s5_idle_timeout", 60);

    // Short pulse from requester 1 during SHIFT is dropped.
    clear_logs();
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (5) tick();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    wait_idle("s6_idle_timeout", 60);
    repeat (5) tick();
    cnt1 = 0;
    foreach (gnt_q[i]) if (gnt_q[i] == 1) cnt1++;
    chk("s6_no_gnt1", 64'(cnt1), 64'd0);
    chk("s6_rsp_count", 64'(rid_q.size()), 64'd1);
    if (rid_q.size() == 1) chk("s6_rsp_id", 64'(rid_q[0]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_convert_arbiter.md
Name: bcd_convert_arbiter

Overview:
- Time-shares one sequential double-dabble binary-to-BCD engine between NUM_REQ requesters, e.g. tempo, note counter and sample counter feeding the display.
- Round-robin arbitration. Each request is a 24-bit binary value.
- Returns an 8-digit packed BCD result tagged with the requester index, over a valid/ready response channel.
- Replaces per-source combinational converters with a single 1-bit-per-cycle engine.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BIN_W, 24, binary input width.
- BCD_DIGITS, 8, BCD output digits; must satisfy 10^BCD_DIGITS > 2^BIN_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request strobe, level.
- req_bin  in  NUM_REQ*BIN_W  packed binary operands; requester i occupies bits [i*BIN_W +: BIN_W].
- req_ready  out  NUM_REQ  one-hot acceptance; at most one bit high.
- rsp_valid  out  1  result available.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester the result belongs to.
- rsp_bcd  out  4*BCD_DIGITS  packed BCD; digit 0 is bits [3:0].
- rsp_ready  in  1  consumer accepts the result.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset is synchronous, active-high. One clock domain only.
- Reset values: state=IDLE, rsp_valid=0, rsp_id=0, rsp_bcd=0, busy=0, rr_ptr=0 (index 0 has highest priority first).
- States: IDLE, SHIFT, DONE.
- IDLE:
  - req_ready is combinational, high only in IDLE, and goes to the first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - Accept happens on an edge where req_valid[g] & req_ready[g] = 1. At that edge:
    - capture req_bin[g] into the shift register;
    - clear the BCD accumulator;
    - rsp_id <= g;
    - rr_ptr <= (g+1) mod NUM_REQ;
    - bit counter <= BIN_W-1;
    - state -> SHIFT.
  - With no request, stay in IDLE with req_ready=0.
- SHIFT, one operand bit per clock, MSB first:
  - add 3 to every accumulator digit >= 5;
  - then shift the accumulator left 1 and insert the next operand bit at bit 0.
  - After exactly BIN_W SHIFT cycles: state -> DONE, rsp_valid <= 1, rsp_bcd <= final accumulator.
  - req_ready=0 throughout SHIFT.
- Latency: rsp_valid is first visible BIN_W+1 clocks after the accepting edge (25 at default).
- DONE:
  - rsp_valid, rsp_id and rsp_bcd hold stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid <= 0 and state -> IDLE. rsp_bcd and rsp_id keep their last values.
  - The next accept happens no earlier than the following edge. No overlap, no pipelining.
  - Maximum throughput is one conversion per BIN_W+2 clocks.
- rsp_ready high in IDLE or SHIFT has no effect.
- req_valid may drop before grant; the request is simply not taken and nothing is queued.
- req_bin is sampled only at the accept edge and may change afterwards.
- Fairness: a continuously requesting source waits at most NUM_REQ-1 conversions.
- Several req_valid bits rising in the same cycle: rr_ptr order decides. Exactly one is granted.
- Reset asserted mid-SHIFT or in DONE:
  - abort to IDLE;
  - the in-flight result is discarded (rsp_valid=0 on the next cycle);
  - rr_ptr returns to 0.
- Arithmetic is unsigned. The accumulator is 4*BCD_DIGITS wide, and the digit adjust is applied to all digits every SHIFT cycle.
- Boundary values:
  - 0 yields all-zero BCD;
  - 2^BIN_W-1 = 16777215 yields 32'h16777215;
  - no overflow is possible given the parameter constraint.

Decomposition:
- Package bcd_pkg holds:
  - the state enum typedef (IDLE, SHIFT, DONE);
  - localparams BIN_W_DEF=24 and BCD_DIGITS_DEF=8;
  - a function for the digit add-3 adjust.
- Sub-module bcd_dabble_seq holds the engine: shift register, accumulator and bit counter, with a start/done interface.
- The top level contains the round-robin arbiter, FSM and response register.

Test Plan:
- Reset, then req_valid=4'b0001 with req_bin[0]=24'd0 -> req_ready=0001 on that cycle; rsp_valid after 25 clocks; rsp_bcd=0, rsp_id=0.
- Requester 2 sends 24'd16777215 with rsp_ready held 0 for 10 cycles after rsp_valid -> rsp_bcd=32'h16777215 and rsp_id=2 hold stable all 10 cycles; busy=1; req_ready=0.
- All four requesters valid continuously with operands 1234, 99999, 5, 8388608 -> grant order 0,1,2,3,0; results 32'h00001234, 32'h00099999, 32'h00000005, 32'h08388608.
- Sweep a single requester over 1000 random 24-bit values -> every rsp_bcd equals the decimal digits of its operand; spacing is 26 clocks with rsp_ready tied high.
- Assert rst 10 clocks into SHIFT -> next cycle rsp_valid=0, busy=0, state IDLE; a new request from requester 3 is granted before requester 0 only if requester 0 is idle (rr_ptr=0).
- req_valid[1] pulsed for 1 cycle while the engine is in SHIFT -> never granted, no response for id 1.
